// File: rtl/fifo_rd_packer_pkg.sv
// Shared definitions for the FIFO read-side packer: state encodings,
// counter sizing and the lane keep-mask helper.
package fifo_rd_packer_pkg;

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Contiguous mask with the low n lanes set.
  function automatic logic [31:0] keep_mask(input int n);
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/fifo_idle_timer.sv
// Idle down-counter: reloads on clear, counts enabled cycles and pulses done
// on the TIMEOUT-th one. Used only when FIFO_RD_PACKER_TIMEOUT_EN is defined.
module fifo_idle_timer
  import fifo_rd_packer_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic r_clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int CW = cnt_width(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge r_clk) begin
    if (!rst || clr) begin
      cnt <= CW'(TIMEOUT);
    end else if (en && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  // Stops at zero so done is a single pulse per idle period.
  assign done = en & (cnt == CW'(1));

endmodule

// File: rtl/fifo_rd_packer.sv
// Packs PACK consecutive FIFO entries into one output word; partial words
// leave on flush, or on idle timeout when FIFO_RD_PACKER_TIMEOUT_EN is defined.
//
// state | meaning
// FILL  | normal pop/capture
// FLUSH | partial emit pending, pops stopped until the last read returns
// HOLD  | word complete, waiting for the output slot
module fifo_rd_packer
  import fifo_rd_packer_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                  r_clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [WIDTH-1:0]      fifo_rdata,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]       out_keep,
  output logic [7:0]            rd_count
);

  localparam int CW = cnt_width(PACK);
  localparam int DW = WIDTH * PACK;
  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  if (PACK < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("fifo_rd_packer: PACK must be >= 2 and TIMEOUT >= 1");
  end

  logic [1:0]      state, state_nxt;
  logic [CW-1:0]   issued, issued_nxt;
  logic [CW-1:0]   got, got_nxt;
  logic            rd_pend;
  logic [DW-1:0]   asm_q, asm_cap;
  logic            slot_free, word_done, flush_req, load;
  logic [PACK-1:0] load_keep;

  assign slot_free  = ~out_valid | out_ready;
  assign word_done  = rd_pend & (got == PACK_C - CW'(1));
  assign fifo_rd_en = rst & ~fifo_empty & (issued < PACK_C) & (state != FLUSH);

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
  logic idle_en, idle_done;

  assign idle_en = (got != '0) & ~rd_pend & fifo_empty;

  fifo_idle_timer #(.TIMEOUT(TIMEOUT)) u_idle_timer (
    .r_clk (r_clk),
    .rst   (rst),
    .clr   (rd_pend | load),
    .en    (idle_en),
    .done  (idle_done)
  );

  assign flush_req = flush | idle_done;
`else
  assign flush_req = flush;
`endif

  // Assembly including any entry returning this cycle.
  always_comb begin
    asm_cap = asm_q;
    for (int k = 0; k < PACK; k++) begin
      if (rd_pend && got == CW'(k)) asm_cap[k*WIDTH +: WIDTH] = fifo_rdata;
    end
  end

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    load_keep  = '1;
    got_nxt    = rd_pend ? got + CW'(1) : got;
    issued_nxt = issued + CW'(fifo_rd_en);
    case (state)
      FILL: begin
        // A completing capture wins over a same-cycle flush.
        if (word_done) begin
          if (slot_free) load = 1'b1;
          else           state_nxt = HOLD;
        end else if (flush_req && (got != '0 || rd_pend)) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (word_done) begin
          if (slot_free) begin
            load      = 1'b1;
            state_nxt = FILL;
          end else begin
            state_nxt = HOLD;
          end
        end else if (!rd_pend && slot_free) begin
          load      = 1'b1;
          load_keep = PACK'(keep_mask(int'(got)));
          state_nxt = FILL;
        end
      end
      HOLD: begin
        if (slot_free) begin
          load      = 1'b1;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
    if (load) begin
      issued_nxt = '0;
      got_nxt    = '0;
    end
  end

  always_ff @(posedge r_clk) begin
    if (!rst) begin
      state     <= FILL;
      issued    <= '0;
      got       <= '0;
      rd_pend   <= 1'b0;
      asm_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      rd_count  <= '0;
    end else begin
      state   <= state_nxt;
      issued  <= issued_nxt;
      got     <= got_nxt;
      rd_pend <= fifo_rd_en;
      asm_q   <= load ? '0 : asm_cap;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= asm_cap;
        out_keep  <= load_keep;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && rd_count != 8'hFF) rd_count <= rd_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a behavioural FIFO model; the
// timeout case follows FIFO_RD_PACKER_TIMEOUT_EN.
module tb_fifo_rd_packer;

  localparam int WIDTH   = 8;
  localparam int PACK    = 4;
  localparam int TIMEOUT = 16;

  logic        r_clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_rdata = 8'h00;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic [7:0]  rd_count;

  fifo_rd_packer #(.WIDTH(WIDTH), .PACK(PACK), .TIMEOUT(TIMEOUT)) dut (
    .r_clk      (r_clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rd_en (fifo_rd_en),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_keep   (out_keep),
    .rd_count   (rd_count)
  );

  always #5 r_clk = ~r_clk;

  logic [7:0]  q[$];
  logic [7:0]  pend[$];
  logic [31:0] wq_data[$];
  logic [3:0]  wq_keep[$];
  logic        force_empty = 1'b0;
  int underflow = 0;
  int pops = 0;
  int viol = 0;
  int nvec = 0;
  int nmis = 0;

  // FIFO model: registered read data, empty flag updated on the clock.
  always @(posedge r_clk) begin
    if (fifo_rd_en) begin
      if (q.size() == 0) underflow++;
      else fifo_rdata <= q.pop_front();
    end
    while (pend.size() > 0) q.push_back(pend.pop_front());
    fifo_empty <= force_empty || (q.size() == 0);
  end

  always @(negedge r_clk) begin
    if (fifo_rd_en) pops++;
    if (fifo_rd_en && fifo_empty) viol++;
    if (out_valid && out_ready) begin
      wq_data.push_back(out_data);
      wq_keep.push_back(out_keep);
    end
  end

  typedef struct {
    int          n;
    logic [31:0] bytes;
    logic        do_flush;
    logic [31:0] exp_data;
    logic [3:0]  exp_keep;
  } vec_t;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge r_clk);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] v);
    pend.push_back(v);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic clear_words();
    wq_data.delete();
    wq_keep.delete();
  endtask

  task automatic wait_words(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (wq_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({nm, "_count"}, 64'(wq_data.size()), 64'(n));
  endtask

  task automatic expect_word(input string nm, input logic [31:0] d, input logic [3:0] kp);
    logic [31:0] ad;
    logic [3:0]  ak;
    ad = '0;
    ak = '0;
    if (wq_data.size() > 0) begin
      ad = wq_data.pop_front();
      ak = wq_keep.pop_front();
    end
    check({nm, "_data"}, 64'(ad), 64'(d));
    check({nm, "_keep"}, 64'(ak), 64'(kp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[6];
    int          c0, c1, np, p0, v0, nb, bad;
    logic        vlow;
    logic [31:0] w;
    logic [3:0]  kk;

    tbl[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF};
    tbl[1] = '{2, 32'h00002211, 1'b1, 32'h00002211, 4'h3};
    tbl[2] = '{4, 32'hD4C3B2A1, 1'b0, 32'hD4C3B2A1, 4'hF};
    tbl[3] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'h1};
    tbl[4] = '{3, 32'h00030201, 1'b1, 32'h00030201, 4'h7};
    tbl[5] = '{4, 32'h00FF00FF, 1'b0, 32'h00FF00FF, 4'hF};

    // Reset with data already waiting: no pop may be issued.
    rst = 1'b0;
    push(8'hE5);
    tick(3);
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_data", 64'(out_data), 64'(0));
    check("rst_keep", 64'(out_keep), 64'(0));
    check("rst_count", 64'(rd_count), 64'(0));
    check("rst_rd_en", 64'(fifo_rd_en), 64'(0));
    rst = 1'b1;
    tick(6);
    pulse_flush();
    wait_words(1, 20, "single");
    expect_word("single", 32'h000000E5, 4'h1);
    tick();
    check("count_after_single", 64'(rd_count), 64'(1));

    // Flush with nothing assembled is ignored.
    pulse_flush();
    tick(10);
    check("idle_flush_words", 64'(wq_data.size()), 64'(0));

    // Latency: first pop to out_valid, one-cycle valid with out_ready=1.
    c0 = -1;
    c1 = -1;
    vlow = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int t = 0; t < 25; t++) begin
      if (c0 < 0 && fifo_rd_en) c0 = t;
      if (c1 < 0 && out_valid) c1 = t;
      else if (c1 >= 0 && t == c1 + 1) vlow = out_valid;
      tick();
    end
    check("pop_to_valid", 64'(c1 - c0), 64'(5));
    check("valid_one_cycle", 64'(vlow), 64'(0));
    wait_words(1, 5, "latency");
    expect_word("latency", 32'h44332211, 4'hF);
    check("count_after_latency", 64'(rd_count), 64'(2));

    for (int i = 0; i < 6; i++) begin
      clear_words();
      for (int k = 0; k < tbl[i].n; k++) push(tbl[i].bytes[8*k +: 8]);
      tick(10);
      if (tbl[i].do_flush) pulse_flush();
      wait_words(1, 20, $sformatf("vec%0d", i));
      expect_word($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_keep);
    end

    // Flush on the same cycle as the completing capture is dropped.
    clear_words();
    push(8'h51); push(8'h52); push(8'h53); push(8'h54);
    tick();
    np = 0;
    for (int t = 0; t < 20; t++) begin
      if (fifo_rd_en) np++;
      if (np == 4) break;
      tick();
    end
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(10);
    check("collide_words", 64'(wq_data.size()), 64'(1));
    expect_word("collide", 32'h54535251, 4'hF);

    clear_words();
    push(8'hAA);
`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    wait_words(1, 40, "timeout");
    expect_word("timeout", 32'h000000AA, 4'h1);
`else
    tick(40);
    check("no_timeout_words", 64'(wq_data.size()), 64'(0));
    pulse_flush();
    wait_words(1, 20, "no_timeout_flush");
    expect_word("no_timeout_flush", 32'h000000AA, 4'h1);
`endif

    // Backpressure: only two words' worth of pops while stalled.
    clear_words();
    p0 = pops;
    out_ready = 1'b0;
    for (int i = 1; i <= 12; i++) push(8'(i));
    tick(20);
    check("bp_pops", 64'(pops - p0), 64'(8));
    out_ready = 1'b1;
    wait_words(3, 40, "bp");
    expect_word("bp0", 32'h04030201, 4'hF);
    expect_word("bp1", 32'h08070605, 4'hF);
    expect_word("bp2", 32'h0C0B0A09, 4'hF);

    // Random empty flag and backpressure; byte stream must survive intact.
    clear_words();
    v0 = viol;
    for (int i = 0; i < 100; i++) push(8'(i * 7 + 3));
    for (int i = 0; i < 1000; i++) begin
      force_empty = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    force_empty = 1'b0;
    out_ready = 1'b1;
    tick(40);
    pulse_flush();
    tick(10);
    check("guard_rd_en_while_empty", 64'(viol - v0), 64'(0));
    nb = 0;
    bad = 0;
    while (wq_data.size() > 0) begin
      w = wq_data.pop_front();
      kk = wq_keep.pop_front();
      for (int k = 0; k < 4; k++) begin
        if (kk[k]) begin
          if (nb < 100 && w[8*k +: 8] !== 8'(nb * 7 + 3)) bad++;
          nb++;
        end
      end
    end
    check("guard_bytes", 64'(nb), 64'(100));
    check("guard_order", 64'(bad), 64'(0));

    // Reset mid-word discards the partial assembly.
    clear_words();
    push(8'h31); push(8'h32); push(8'h33);
    tick(8);
    rst = 1'b0;
    tick();
    check("midrst_valid", 64'(out_valid), 64'(0));
    check("midrst_data", 64'(out_data), 64'(0));
    check("midrst_keep", 64'(out_keep), 64'(0));
    check("midrst_count", 64'(rd_count), 64'(0));
    check("midrst_rd_en", 64'(fifo_rd_en), 64'(0));
    rst = 1'b1;
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    wait_words(1, 30, "post_rst");
    expect_word("post_rst", 32'h44434241, 4'hF);
    tick();
    check("post_rst_count", 64'(rd_count), 64'(1));

    // rd_count saturation at 255.
    for (int i = 0; i < 1016; i++) push(8'(i));
    wait_words(254, 3000, "sat");
    tick(2);
    check("sat_count", 64'(rd_count), 64'(255));
    clear_words();
    for (int i = 0; i < 8; i++) push(8'(i));
    wait_words(2, 40, "sat_hold");
    tick(2);
    check("sat_hold_count", 64'(rd_count), 64'(255));

    check("underflow", 64'(underflow), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
